clock_enable_generator_mc: RTL and testbench



---
 rtl/clock_enable_generator_mc.sv | 102 ++++++++++
 tb/tb_clock_enable_generator_mc.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_enable_generator_mc.sv
// Multi-channel programmable clock-enable generator: per-channel divisor, pulse/toggle
// mode, run/halt control and edge-detected single step. All state lives in the clk_in domain.
module clock_enable_generator_mc #(
   parameter int NUM_CH      = 2,
   parameter int DIV_W       = 29,
   parameter int DEFAULT_DIV = 99_999_999,
   parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_sel,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic              cfg_mode,
   input  logic [NUM_CH-1:0] run,
   input  logic [NUM_CH-1:0] step,
   output logic [NUM_CH-1:0] clk_enable,
   output logic [NUM_CH-1:0] wrap
);

   localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] CNT_ZERO  = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0] CNT_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};

   logic [NUM_CH-1:0] step_q_r;

   // Step history; preset to ones so a step held through reset never fires.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         step_q_r <= {NUM_CH{1'b1}};
      end else begin
         step_q_r <= step;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [DIV_W-1:0] cnt_r, cnt_s;
      logic [DIV_W-1:0] div_r, div_s;
      logic             mode_r, mode_s;
      logic             en_r, en_s;
      logic             wrap_r, wrap_s;
      logic             cfg_hit_s;
      logic             step_evt_s;

      // Next-state: config write > step (halted only) > run/halt.
      always_comb begin
         cnt_s      = cnt_r;
         div_s      = div_r;
         mode_s     = mode_r;
         en_s       = en_r;
         wrap_s     = 1'b0;
         cfg_hit_s  = cfg_we && (cfg_sel == CH_W'(i));
         step_evt_s = step[i] && !step_q_r[i];
         if (cfg_hit_s) begin
            div_s  = cfg_div;
            mode_s = cfg_mode;
            cnt_s  = CNT_ZERO;
            en_s   = 1'b0;
            wrap_s = 1'b0;
         end else if (step_evt_s && !run[i]) begin
            cnt_s  = CNT_ZERO;
            wrap_s = 1'b1;
            en_s   = mode_r ? ~en_r : 1'b1;
         end else if (run[i]) begin
            if (cnt_r == div_r) begin
               cnt_s  = CNT_ZERO;
               wrap_s = 1'b1;
               en_s   = mode_r ? ~en_r : 1'b1;
            end else begin
               cnt_s  = cnt_r + CNT_ONE;
               wrap_s = 1'b0;
               en_s   = mode_r ? en_r : 1'b0;
            end
         end else begin
            // Halted: toggle level is frozen, pulse output drops.
            wrap_s = 1'b0;
            en_s   = mode_r ? en_r : 1'b0;
         end
      end

      // Channel state and registered outputs.
      always_ff @(posedge clk_in) begin
         if (rst) begin
            cnt_r  <= CNT_ZERO;
            div_r  <= DIV_RESET;
            mode_r <= 1'b0;
            en_r   <= 1'b0;
            wrap_r <= 1'b0;
         end else begin
            cnt_r  <= cnt_s;
            div_r  <= div_s;
            mode_r <= mode_s;
            en_r   <= en_s;
            wrap_r <= wrap_s;
         end
      end

      assign clk_enable[i] = en_r;
      assign wrap[i]       = wrap_r;
   end

endmodule

// File: tb/tb_clock_enable_generator_mc.sv
// Directed self-checking bench for clock_enable_generator_mc (2-channel and 3-channel instances).
module tb_clock_enable_generator_mc;

   logic       clk_in;
   logic       rst, rst3;
   logic       cfg_we, cfg_we3;
   logic       cfg_sel;
   logic [1:0] cfg_sel3;
   logic [7:0] cfg_div;
   logic       cfg_mode;
   logic [1:0] run, step, clk_enable, wrap;
   logic [2:0] run3, step3, clk_enable3, wrap3;

   int checks = 0;
   int errors = 0;
   int g = 0;

   clock_enable_generator_mc #(.NUM_CH(2), .DIV_W(8), .DEFAULT_DIV(9)) dut (
      .clk_in(clk_in), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_div(cfg_div),
      .cfg_mode(cfg_mode), .run(run), .step(step), .clk_enable(clk_enable), .wrap(wrap));

   clock_enable_generator_mc #(.NUM_CH(3), .DIV_W(8), .DEFAULT_DIV(9)) dut3 (
      .clk_in(clk_in), .rst(rst3), .cfg_we(cfg_we3), .cfg_sel(cfg_sel3), .cfg_div(cfg_div),
      .cfg_mode(cfg_mode), .run(run3), .step(step3), .clk_enable(clk_enable3), .wrap(wrap3));

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; rst3 = 1'b1; run = 2'b11; run3 = 3'b111;
      tick(); tick();
      checks++; if (clk_enable !== 2'b00) begin errors++; $display("FAIL reset_en: got %b expected 00", clk_enable); end
      checks++; if (wrap !== 2'b00) begin errors++; $display("FAIL reset_wrap: got %b expected 00", wrap); end
      checks++; if (clk_enable3 !== 3'b000) begin errors++; $display("FAIL reset_en3: got %b expected 000", clk_enable3); end
      checks++; if (wrap3 !== 3'b000) begin errors++; $display("FAIL reset_wrap3: got %b expected 000", wrap3); end
      rst = 1'b0;
   endtask

   task automatic test_pulse();
      logic [1:0] e;
      for (int c = 1; c <= 30; c++) begin
         tick(); g++;
         e = (c % 10 == 0) ? 2'b11 : 2'b00;
         checks++; if (wrap !== e) begin errors++; $display("FAIL pulse_wrap cyc %0d: got %b expected %b", c, wrap, e); end
         checks++; if (clk_enable !== e) begin errors++; $display("FAIL pulse_en cyc %0d: got %b expected %b", c, clk_enable, e); end
      end
   endtask

   task automatic test_toggle();
      logic e0, w1, e1;
      cfg_we = 1'b1; cfg_sel = 1'b1; cfg_div = 8'd3; cfg_mode = 1'b1;
      tick(); g++;
      cfg_we = 1'b0;
      checks++; if ({clk_enable[1], wrap[1]} !== 2'b00) begin errors++; $display("FAIL toggle_cfg ch1: got %b expected 00", {clk_enable[1], wrap[1]}); end
      for (int k = 1; k <= 24; k++) begin
         tick(); g++;
         w1 = (k % 4 == 0);
         e1 = ((k / 4) % 2 == 1);
         e0 = (g % 10 == 0);
         checks++; if (wrap[1] !== w1) begin errors++; $display("FAIL toggle_wrap1 k %0d: got %b expected %b", k, wrap[1], w1); end
         checks++; if (clk_enable[1] !== e1) begin errors++; $display("FAIL toggle_en1 k %0d: got %b expected %b", k, clk_enable[1], e1); end
         checks++; if (clk_enable[0] !== e0) begin errors++; $display("FAIL toggle_ch0_en k %0d: got %b expected %b", k, clk_enable[0], e0); end
      end
   endtask

   task automatic test_div0();
      logic e;
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_div = 8'd0; cfg_mode = 1'b0;
      tick();
      cfg_we = 1'b0;
      checks++; if ({clk_enable[0], wrap[0]} !== 2'b00) begin errors++; $display("FAIL div0_cfg: got %b expected 00", {clk_enable[0], wrap[0]}); end
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++; if ({clk_enable[0], wrap[0]} !== 2'b11) begin errors++; $display("FAIL div0_pulse k %0d: got %b expected 11", k, {clk_enable[0], wrap[0]}); end
      end
      cfg_we = 1'b1; cfg_mode = 1'b1;
      tick();
      cfg_we = 1'b0;
      checks++; if ({clk_enable[0], wrap[0]} !== 2'b00) begin errors++; $display("FAIL div0_cfg_toggle: got %b expected 00", {clk_enable[0], wrap[0]}); end
      for (int k = 1; k <= 6; k++) begin
         tick();
         e = (k % 2 == 1);
         checks++; if (wrap[0] !== 1'b1) begin errors++; $display("FAIL div0_toggle_wrap k %0d: got %b expected 1", k, wrap[0]); end
         checks++; if (clk_enable[0] !== e) begin errors++; $display("FAIL div0_toggle_en k %0d: got %b expected %b", k, clk_enable[0], e); end
      end
   endtask

   task automatic test_halt_step();
      logic e;
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_div = 8'd9; cfg_mode = 1'b0;
      tick();
      cfg_we = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++; if (wrap[0] !== 1'b0) begin errors++; $display("FAIL halt_prerun k %0d: got %b expected 0", k, wrap[0]); end
      end
      run[0] = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++; if ({clk_enable[0], wrap[0]} !== 2'b00) begin errors++; $display("FAIL halt_idle k %0d: got %b expected 00", k, {clk_enable[0], wrap[0]}); end
      end
      step[0] = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         e = (k == 1);
         checks++; if (wrap[0] !== e) begin errors++; $display("FAIL step_wrap k %0d: got %b expected %b", k, wrap[0], e); end
         checks++; if (clk_enable[0] !== e) begin errors++; $display("FAIL step_en k %0d: got %b expected %b", k, clk_enable[0], e); end
      end
      step[0] = 1'b0;
      tick();
      run[0] = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         step[0] = (k == 13 || k == 14);
         tick();
         e = (k % 10 == 0);
         checks++; if (wrap[0] !== e) begin errors++; $display("FAIL resume_wrap k %0d: got %b expected %b", k, wrap[0], e); end
         checks++; if (clk_enable[0] !== e) begin errors++; $display("FAIL resume_en k %0d: got %b expected %b", k, clk_enable[0], e); end
      end
   endtask

   task automatic test_reset_mid();
      logic e;
      run[1] = 1'b0;
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_div = 8'd1; cfg_mode = 1'b1;
      tick();
      cfg_we = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         e = ((k / 2) % 2 == 1);
         checks++; if (clk_enable[0] !== e) begin errors++; $display("FAIL tog1_en k %0d: got %b expected %b", k, clk_enable[0], e); end
      end
      run[0] = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++; if ({clk_enable[0], wrap[0]} !== 2'b10) begin errors++; $display("FAIL tog_hold k %0d: got %b expected 10", k, {clk_enable[0], wrap[0]}); end
      end
      step[0] = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (clk_enable !== 2'b00) begin errors++; $display("FAIL midrst_en: got %b expected 00", clk_enable); end
      checks++; if (wrap !== 2'b00) begin errors++; $display("FAIL midrst_wrap: got %b expected 00", wrap); end
      for (int k = 1; k <= 5; k++) begin
         tick();
         checks++; if ({clk_enable[0], wrap[0]} !== 2'b00) begin errors++; $display("FAIL midrst_heldstep k %0d: got %b expected 00", k, {clk_enable[0], wrap[0]}); end
      end
      step[0] = 1'b0; tick();
      step[0] = 1'b1; tick();
      checks++; if ({clk_enable[0], wrap[0]} !== 2'b11) begin errors++; $display("FAIL midrst_newstep: got %b expected 11", {clk_enable[0], wrap[0]}); end
      step[0] = 1'b0; tick();
      checks++; if (clk_enable[0] !== 1'b0) begin errors++; $display("FAIL midrst_pulse_mode: got %b expected 0", clk_enable[0]); end
      run[0] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         e = (k == 10);
         checks++; if (wrap[0] !== e) begin errors++; $display("FAIL midrst_div k %0d: got %b expected %b", k, wrap[0], e); end
      end
   endtask

   task automatic test_cfg_step();
      logic e;
      cfg_we = 1'b1; cfg_sel = 1'b1; cfg_div = 8'd5; cfg_mode = 1'b0; step[1] = 1'b1;
      tick();
      cfg_we = 1'b0;
      checks++; if ({clk_enable[1], wrap[1]} !== 2'b00) begin errors++; $display("FAIL cfgstep_same: got %b expected 00", {clk_enable[1], wrap[1]}); end
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++; if ({clk_enable[1], wrap[1]} !== 2'b00) begin errors++; $display("FAIL cfgstep_held k %0d: got %b expected 00", k, {clk_enable[1], wrap[1]}); end
      end
      step[1] = 1'b0; tick();
      run[1] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         e = (k % 6 == 0);
         checks++; if (wrap[1] !== e) begin errors++; $display("FAIL cfgstep_div5 k %0d: got %b expected %b", k, wrap[1], e); end
      end
   endtask

   task automatic test_invalid_sel();
      logic [2:0] e;
      rst3 = 1'b1; run3 = 3'b111;
      tick();
      rst3 = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         cfg_we3 = (k == 3); cfg_sel3 = 2'd3; cfg_div = 8'd2; cfg_mode = 1'b1;
         tick();
         e = (k % 10 == 0) ? 3'b111 : 3'b000;
         checks++; if (wrap3 !== e) begin errors++; $display("FAIL badsel_wrap k %0d: got %b expected %b", k, wrap3, e); end
         checks++; if (clk_enable3 !== e) begin errors++; $display("FAIL badsel_en k %0d: got %b expected %b", k, clk_enable3, e); end
      end
      cfg_we3 = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rst3 = 1'b1; cfg_we = 1'b0; cfg_we3 = 1'b0; cfg_sel = 1'b0; cfg_sel3 = 2'd0;
      cfg_div = 8'd0; cfg_mode = 1'b0; run = 2'b11; run3 = 3'b111; step = 2'b00; step3 = 3'b000;
      test_reset();
      test_pulse();
      test_toggle();
      test_div0();
      test_halt_step();
      test_reset_mid();
      test_cfg_step();
      test_invalid_sel();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
